// File: rtl/agc_pkg.sv
// Package for the AGC gain stepper: FSM state encoding, settle-counter width
// and terminal value, and a small helper for the event counters.
package agc_pkg;

   localparam int SETTLE_W = 4;
   localparam logic [SETTLE_W-1:0] SETTLE_TERM = 4'b1111;

   typedef enum logic [1:0] {
      S_IDLE   = 2'b00,
      S_SETTLE = 2'b01,
      S_DONE   = 2'b10
   } agc_state_t;

   // Increment a 4-bit event counter without wrapping past the terminal value.
   function automatic logic [SETTLE_W-1:0] cnt_inc4(input logic [SETTLE_W-1:0] v,
                                                   input logic                en);
      logic [SETTLE_W-1:0] r;
      r = v;
      if (en && (v != SETTLE_TERM)) begin
         r = v + 4'd1;
      end else begin
         r = v;
      end
      return r;
   endfunction

endpackage

// File: rtl/agc_gain_sat.sv
// Combinational saturating gain step: computes gain +/- STEP in GAIN_W+1 bits
// and clamps to [GAIN_MIN, GAIN_MAX], flagging when the clamp was applied.
module agc_gain_sat #(
   parameter int GAIN_W   = 6,
   parameter int GAIN_MIN = 0,
   parameter int GAIN_MAX = 63,
   parameter int STEP     = 1
) (
   input  logic [GAIN_W-1:0] gain,
   input  logic              up_dn,
   output logic [GAIN_W-1:0] next_gain,
   output logic              clipped
);
   localparam logic [GAIN_W:0] STEP_X = (GAIN_W+1)'(STEP);
   localparam logic [GAIN_W:0] MIN_X  = (GAIN_W+1)'(GAIN_MIN);
   localparam logic [GAIN_W:0] MAX_X  = (GAIN_W+1)'(GAIN_MAX);

   logic [GAIN_W:0] gain_ext;
   logic [GAIN_W:0] up_val;
   logic [GAIN_W:0] dn_val;

   // Step in the widened domain; the down path is range-checked before the
   // subtraction result is used, so no underflow can leak through.
   always_comb begin
      gain_ext  = {1'b0, gain};
      up_val    = gain_ext + STEP_X;
      dn_val    = gain_ext - STEP_X;
      next_gain = gain;
      clipped   = 1'b0;
      if (up_dn) begin
         if (up_val > MAX_X) begin
            next_gain = MAX_X[GAIN_W-1:0];
            clipped   = 1'b1;
         end else begin
            next_gain = up_val[GAIN_W-1:0];
            clipped   = 1'b0;
         end
      end else begin
         if (gain_ext < (MIN_X + STEP_X)) begin
            next_gain = MIN_X[GAIN_W-1:0];
            clipped   = 1'b1;
         end else begin
            next_gain = dn_val[GAIN_W-1:0];
            clipped   = 1'b0;
         end
      end
   end

endmodule

// File: rtl/agc_gain_stepper.sv
// AGC gain stepper: settle counter for the controller, one saturating gain
// step per adjust window, and sticky convergence detection (direction
// reversals or consecutive clipped steps).
// Optional feature macro AGC_STEP_TIMEOUT_EN: a 6-bit window counter also
// declares convergence on the 63rd step.
module agc_gain_stepper
   import agc_pkg::*;
#(
   parameter int GAIN_W    = 6,
   parameter int GAIN_INIT = 32,
   parameter int GAIN_MIN  = 0,
   parameter int GAIN_MAX  = 63,
   parameter int STEP      = 1,
   parameter int REV_LIMIT = 3,
   parameter int SAT_LIMIT = 2
) (
   input  logic                clk,
   input  logic                RESETn,
   input  logic                counter2_mode,
   input  logic                adjust,
   input  logic                up_dn,
   output logic [SETTLE_W-1:0] counter2,
   output logic [GAIN_W-1:0]   gain,
   output logic                gain_valid,
   output logic                sat_hi,
   output logic                sat_lo,
   output logic                done
);
   localparam logic [SETTLE_W-1:0] REV_LIM4 = SETTLE_W'(REV_LIMIT);
   localparam logic [SETTLE_W-1:0] SAT_LIM4 = SETTLE_W'(SAT_LIMIT);
   localparam logic [GAIN_W-1:0]   INIT_G   = GAIN_W'(GAIN_INIT);
   localparam logic [GAIN_W-1:0]   MAX_G    = GAIN_W'(GAIN_MAX);
   localparam logic [GAIN_W-1:0]   MIN_G    = GAIN_W'(GAIN_MIN);

   logic [1:0]          rst_sync;
   logic                rst_n;
   agc_state_t          state;
   agc_state_t          state_nxt;
   logic [GAIN_W-1:0]   next_gain;
   logic                clipped;
   logic                step_edge;
   logic                rev;
   logic [SETTLE_W-1:0] rev_cnt;
   logic [SETTLE_W-1:0] rev_next;
   logic [SETTLE_W-1:0] sat_cnt;
   logic [SETTLE_W-1:0] sat_next;
   logic                last_dir;
   logic                have_dir;
   logic                timeout_hit;
   logic                set_done;

   // Reset synchronizer: assertion reaches the state immediately, release is clocked.
   always_ff @(posedge clk or negedge RESETn) begin
      if (!RESETn) begin
         rst_sync <= 2'b00;
      end else begin
         rst_sync <= {rst_sync[0], 1'b1};
      end
   end
   assign rst_n = rst_sync[1];

   agc_gain_sat #(
      .GAIN_W   (GAIN_W),
      .GAIN_MIN (GAIN_MIN),
      .GAIN_MAX (GAIN_MAX),
      .STEP     (STEP)
   ) u_sat (
      .gain      (gain),
      .up_dn     (up_dn),
      .next_gain (next_gain),
      .clipped   (clipped)
   );

`ifdef AGC_STEP_TIMEOUT_EN
   logic [5:0] win_cnt;

   // Window counter: one count per step edge; the 63rd step forces convergence.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         win_cnt <= 6'd0;
      end else if (step_edge && (win_cnt != 6'd63)) begin
         win_cnt <= win_cnt + 6'd1;
      end else begin
         win_cnt <= win_cnt;
      end
   end
   assign timeout_hit = step_edge && (win_cnt == 6'd62);
`else
   assign timeout_hit = 1'b0;
`endif

   // Step decode and convergence terms evaluated on the step edge.
   always_comb begin
      step_edge = (state == S_IDLE) && adjust;
      rev       = have_dir && (up_dn != last_dir);
      rev_next  = cnt_inc4(rev_cnt, rev);
      sat_next  = clipped ? cnt_inc4(sat_cnt, 1'b1) : 4'd0;
      set_done  = step_edge && ((rev_next >= REV_LIM4) || (sat_next >= SAT_LIM4) || timeout_hit);
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic: one step per window, S_DONE absorbs.
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: begin
            if (adjust) begin
               state_nxt = set_done ? S_DONE : S_SETTLE;
            end else begin
               state_nxt = S_IDLE;
            end
         end
         S_SETTLE: begin
            if (!adjust) begin
               state_nxt = S_IDLE;
            end else begin
               state_nxt = S_SETTLE;
            end
         end
         S_DONE: begin
            state_nxt = S_DONE;
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase
   end

   // Gain, saturation flags, direction history and convergence counters.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         gain       <= INIT_G;
         sat_hi     <= (INIT_G == MAX_G);
         sat_lo     <= (INIT_G == MIN_G);
         gain_valid <= 1'b0;
         done       <= 1'b0;
         rev_cnt    <= 4'd0;
         sat_cnt    <= 4'd0;
         last_dir   <= 1'b0;
         have_dir   <= 1'b0;
      end else begin
         gain_valid <= step_edge;
         if (step_edge) begin
            gain     <= next_gain;
            sat_hi   <= (next_gain == MAX_G);
            sat_lo   <= (next_gain == MIN_G);
            rev_cnt  <= rev_next;
            sat_cnt  <= sat_next;
            last_dir <= up_dn;
            have_dir <= 1'b1;
            done     <= done | set_done;
         end else begin
            gain     <= gain;
            sat_hi   <= sat_hi;
            sat_lo   <= sat_lo;
            rev_cnt  <= rev_cnt;
            sat_cnt  <= sat_cnt;
            last_dir <= last_dir;
            have_dir <= have_dir;
            done     <= done;
         end
      end
   end

   // Settle counter: counts while enabled, wraps at the terminal value, clears when disabled.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         counter2 <= 4'd0;
      end else if (!counter2_mode) begin
         counter2 <= 4'd0;
      end else if (counter2 == SETTLE_TERM) begin
         counter2 <= 4'd0;
      end else begin
         counter2 <= counter2 + 4'd1;
      end
   end

endmodule
